// File: rtl/burst_meter_pkg.sv
// Shared types and defaults for the burst run-length meter.
package burst_meter_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int DROP_W_DEF = 4;
    localparam int STATS_W    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    // The saturation flag sits directly above the length field of a result.
    function automatic int sat_bit(input int cnt_w);
        return cnt_w;
    endfunction

endpackage

// File: rtl/burst_meter_if.sv
// Valid/ready result bus between the burst meter and its consumer.
interface burst_meter_if
    import burst_meter_pkg::*;
#(
    parameter int DATA_W = CNT_W_DEF + 1
) ();

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport master (output res_valid, output res_data, input res_ready);
    modport slave  (input res_valid, input res_data, output res_ready);

endinterface

// File: rtl/burst_meter_fifo.sv
// Two-entry result FIFO with registered head; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module burst_meter_fifo
    import burst_meter_pkg::*;
#(
    parameter int DATA_W = CNT_W_DEF + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] tail_r;
    logic [1:0]        count_r;
    logic [DATA_W-1:0] head_n;
    logic [DATA_W-1:0] tail_n;
    logic [1:0]        count_n;
    logic              pop_eff_s;
    logic              push_eff_s;

    assign full       = (count_r == 2'd2);
    assign empty      = (count_r == 2'd0);
    assign rdata      = head_r;
    assign pop_eff_s  = pop && !empty;
    assign push_eff_s = push && (!full || pop_eff_s);

    // Next-state of the entries; vacated slots are zeroed so the head reads 0 when empty.
    always_comb begin
        head_n  = head_r;
        tail_n  = tail_r;
        count_n = count_r;
        case ({push_eff_s, pop_eff_s})
            2'b10: begin
                if (count_r == 2'd0) begin
                    head_n  = wdata;
                    count_n = 2'd1;
                end else begin
                    tail_n  = wdata;
                    count_n = 2'd2;
                end
            end
            2'b01: begin
                if (count_r == 2'd2) begin
                    head_n = tail_r;
                end else begin
                    head_n = '0;
                end
                tail_n  = '0;
                count_n = count_r - 2'd1;
            end
            2'b11: begin
                if (count_r == 2'd2) begin
                    head_n = tail_r;
                    tail_n = wdata;
                end else begin
                    head_n = wdata;
                    tail_n = '0;
                end
            end
            default: begin
                head_n  = head_r;
                tail_n  = tail_r;
                count_n = count_r;
            end
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            head_r  <= head_n;
            tail_r  <= tail_n;
            count_r <= count_n;
        end
    end

endmodule

// File: rtl/burst_meter.sv
// Burst run-length meter: times each run/last burst and queues {sat, len}.
// Optional BURST_METER_STATS_EN adds burst_cnt and max_len statistics outputs.
module burst_meter
    import burst_meter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              last_i,
    burst_meter_if.master     res,
    output logic              proto_err,
    output logic              drop,
    output logic [DROP_W-1:0] drop_cnt
`ifdef BURST_METER_STATS_EN
    ,
    output logic [STATS_W-1:0] burst_cnt,
    output logic [CNT_W-1:0]   max_len
`endif
);

    localparam int                SAT_BIT  = sat_bit(CNT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_n;
    logic               sat_r;
    logic               sat_n;
    logic               proto_r;
    logic               drop_r;
    logic [DROP_W-1:0]  drop_cnt_r;
    logic               push_s;
    logic               proto_s;
    logic               pop_s;
    logic               drop_s;
    logic               full_s;
    logic               empty_s;
    logic [CNT_W:0]     push_data_s;
    logic [CNT_W:0]     head_s;

    assign push_data_s          = {sat_r, cnt_r};
    assign pop_s                = !empty_s && res.res_ready;
    assign drop_s               = push_s && full_s && !pop_s;
    assign res.res_valid        = !empty_s;
    assign res.res_data         = head_s;
    assign proto_err            = proto_r;
    assign drop                 = drop_r;
    assign drop_cnt             = drop_cnt_r;

    // Burst FSM: start, count, close with a push, or abort on a protocol violation.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        sat_n   = sat_r;
        push_s  = 1'b0;
        proto_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (last_i) begin
                    proto_s = 1'b1;
                end else if (run_i) begin
                    state_n = MEAS;
                    cnt_n   = CNT_ONE;
                    sat_n   = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            MEAS: begin
                if (run_i && !last_i) begin
                    if (cnt_r == CNT_MAX) begin
                        sat_n = 1'b1;
                    end else begin
                        cnt_n = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    sat_n   = 1'b0;
                    if (last_i && !run_i) begin
                        push_s = 1'b1;
                    end else begin
                        proto_s = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                sat_n   = 1'b0;
            end
        endcase
    end

    // FSM, counter and single-cycle event registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            sat_r      <= 1'b0;
            proto_r    <= 1'b0;
            drop_r     <= 1'b0;
            drop_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            sat_r   <= sat_n;
            proto_r <= proto_s;
            drop_r  <= drop_s;
            if (drop_s && (drop_cnt_r != DROP_MAX)) begin
                drop_cnt_r <= drop_cnt_r + DROP_ONE;
            end
        end
    end

    burst_meter_fifo #(
        .DATA_W (CNT_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_data_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

`ifdef BURST_METER_STATS_EN
    logic [STATS_W-1:0] burst_cnt_r;
    logic [CNT_W-1:0]   max_len_r;
    logic               accept_s;

    assign accept_s  = push_s && !drop_s;
    assign burst_cnt = burst_cnt_r;
    assign max_len   = max_len_r;

    // Statistics over accepted results; a saturated length is already CNT_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_r <= '0;
            max_len_r   <= '0;
        end else if (accept_s) begin
            burst_cnt_r <= burst_cnt_r + {{(STATS_W-1){1'b0}}, 1'b1};
            if (push_data_s[CNT_W-1:0] > max_len_r) begin
                max_len_r <= push_data_s[CNT_W-1:0];
            end
        end
    end

    logic unused_sat_s;
    assign unused_sat_s = push_data_s[SAT_BIT];
`endif

endmodule

// File: tb/tb_burst_meter.sv
// Self-checking bench for burst_meter: directed plan plus randomized traffic
// against a queue-based behavioural model (CNT_W=4 so saturation is reachable).
module tb_burst_meter;

    localparam int CNT_W   = 4;
    localparam int DROP_W  = 4;
    localparam int MAX_LEN = 15;
    localparam int MAX_DRP = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              run_i;
    logic              last_i;
    logic              proto_err;
    logic              drop;
    logic [DROP_W-1:0] drop_cnt;
`ifdef BURST_METER_STATS_EN
    logic [15:0]       burst_cnt;
    logic [CNT_W-1:0]  max_len;
`endif

    burst_meter_if #(.DATA_W(CNT_W + 1)) bus ();

    burst_meter #(
        .CNT_W  (CNT_W),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run_i     (run_i),
        .last_i    (last_i),
        .res       (bus),
        .proto_err (proto_err),
        .drop      (drop),
        .drop_cnt  (drop_cnt)
`ifdef BURST_METER_STATS_EN
        ,
        .burst_cnt (burst_cnt),
        .max_len   (max_len)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: unbounded run length, result list, event flags.
    int   m_q[$];
    bit   m_in_burst;
    int   m_len;
    bit   m_proto;
    bit   m_drop;
    int   m_drop_cnt;
    int   m_bursts;
    int   m_max;

    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit l, input bit rdy, input bit rs);
        bit push;
        bit pop;
        int val;
        if (rs) begin
            m_q.delete();
            m_in_burst = 0;
            m_len      = 0;
            m_proto    = 0;
            m_drop     = 0;
            m_drop_cnt = 0;
            m_bursts   = 0;
            m_max      = 0;
            return;
        end
        push    = 0;
        val     = 0;
        m_proto = 0;
        m_drop  = 0;
        pop     = (m_q.size() > 0) && rdy;
        if (!m_in_burst) begin
            if (l) m_proto = 1;
            else if (r) begin
                m_in_burst = 1;
                m_len      = 1;
            end
        end else if (r && !l) begin
            m_len++;
        end else begin
            m_in_burst = 0;
            if (l && !r) begin
                push = 1;
                val  = (m_len > MAX_LEN) ? ((1 << CNT_W) | MAX_LEN) : m_len;
            end else begin
                m_proto = 1;
            end
        end
        if (push && m_q.size() == 2 && !pop) begin
            m_drop = 1;
            if (m_drop_cnt < MAX_DRP) m_drop_cnt++;
            push = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(val);
            m_bursts = (m_bursts + 1) % 65536;
            if ((val & MAX_LEN) > m_max) m_max = val & MAX_LEN;
        end
    endtask

    // Drive one cycle, advance the model, then compare at the following falling edge.
    task automatic cycle(input bit r, input bit l, input bit rdy, input bit rs);
        int exp_data;
        run_i         = r;
        last_i        = l;
        bus.res_ready = rdy;
        rst           = rs;
        model_step(r, l, rdy, rs);
        @(negedge clk);
        exp_data = (m_q.size() > 0) ? m_q[0] : 0;
        check("res_valid", {31'd0, bus.res_valid}, (m_q.size() > 0) ? 32'd1 : 32'd0);
        check("res_data", {27'd0, bus.res_data}, exp_data);
        check("proto_err", {31'd0, proto_err}, {31'd0, m_proto});
        check("drop", {31'd0, drop}, {31'd0, m_drop});
        check("drop_cnt", {28'd0, drop_cnt}, m_drop_cnt);
`ifdef BURST_METER_STATS_EN
        check("burst_cnt", {16'd0, burst_cnt}, m_bursts);
        check("max_len", {28'd0, max_len}, m_max);
`endif
    endtask

    task automatic burst(input int n, input bit rdy);
        repeat (n) cycle(1'b1, 1'b0, rdy, 1'b0);
        cycle(1'b0, 1'b1, rdy, 1'b0);
    endtask

    initial begin
        int  rdy_pct;
        int  pick;
        bit  r;
        bit  l;
        bit  rdy;
        bit  rs;

        run_i         = 1'b0;
        last_i        = 1'b0;
        bus.res_ready = 1'b0;
        rst           = 1'b1;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("lit_rst_valid", {31'd0, bus.res_valid}, 32'd0);
        check("lit_rst_data", {27'd0, bus.res_data}, 32'd0);
        check("lit_rst_dcnt", {28'd0, drop_cnt}, 32'd0);

        // Basic 3-cycle burst: {0,3} one cycle after last
        burst(3, 1'b1);
        check("lit_basic_valid", {31'd0, bus.res_valid}, 32'd1);
        check("lit_basic_data", {27'd0, bus.res_data}, 32'd3);
        check("lit_basic_proto", {31'd0, proto_err}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Saturation: 20 run cycles -> {1,15}
        burst(20, 1'b1);
        check("lit_sat_data", {27'd0, bus.res_data}, 32'd31);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure: 2, 5, 7 with ready low; third is dropped
        burst(2, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        burst(5, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        burst(7, 1'b0);
        check("lit_bp_drop", {31'd0, drop}, 32'd1);
        check("lit_bp_dcnt", {28'd0, drop_cnt}, 32'd1);
        check("lit_bp_head0", {27'd0, bus.res_data}, 32'd2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lit_bp_head1", {27'd0, bus.res_data}, 32'd5);
        check("lit_bp_drop_off", {31'd0, drop}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lit_bp_empty", {31'd0, bus.res_valid}, 32'd0);

        // Protocol errors: last in IDLE, run+last in MEAS, gap in MEAS
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("lit_pe_idle", {31'd0, proto_err}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lit_pe_pulse", {31'd0, proto_err}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("lit_pe_both", {31'd0, proto_err}, 32'd1);
        check("lit_pe_both_q", {31'd0, bus.res_valid}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lit_pe_gap", {31'd0, proto_err}, 32'd1);
        check("lit_pe_gap_q", {31'd0, bus.res_valid}, 32'd0);

        // Reset mid-burst with one result queued
        burst(1, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("lit_mrst_valid", {31'd0, bus.res_valid}, 32'd0);
        check("lit_mrst_dcnt", {28'd0, drop_cnt}, 32'd0);
        burst(2, 1'b1);
        check("lit_mrst_len", {27'd0, bus.res_data}, 32'd2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Full queue push with simultaneous pop
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        burst(3, 1'b0);
        burst(4, 1'b0);
        check("lit_fp_head", {27'd0, bus.res_data}, 32'd3);
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("lit_fp_nodrop", {31'd0, drop}, 32'd0);
        check("lit_fp_head4", {27'd0, bus.res_data}, 32'd4);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lit_fp_head6", {27'd0, bus.res_data}, 32'd6);
`ifdef BURST_METER_STATS_EN
        check("lit_fp_bursts", {16'd0, burst_cnt}, 32'd3);
        check("lit_fp_max", {28'd0, max_len}, 32'd6);
`endif
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lit_fp_empty", {31'd0, bus.res_valid}, 32'd0);

        // Randomized traffic: mostly legal bursts, occasional violations and resets
        rdy_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                pick = $urandom_range(0, 2);
                rdy_pct = (pick == 0) ? 0 : ((pick == 1) ? 30 : 90);
            end
            rs   = ($urandom_range(0, 299) == 0);
            rdy  = ($urandom_range(0, 99) < rdy_pct);
            pick = $urandom_range(0, 31);
            if (m_in_burst) begin
                r = (pick <= 26) || (pick == 31);
                l = (pick >= 27 && pick <= 29) || (pick == 31);
            end else begin
                r = (pick <= 19);
                l = (pick == 20);
            end
            cycle(r, l, rdy, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_meter.md
Name: burst_meter

Overview:
- Downstream consumer of the run/last strobe FSM.
- Takes its `r` level (high every RUN cycle) and its `f` pulse (one LAST cycle).
- Measures the run length of each burst in clock cycles and pushes the result into a 2-entry result queue, drained through a valid/ready interface.
- Flags protocol violations and dropped results.

Parameters:
- CNT_W, 8: width of the run-length counter; lengths saturate at 2^CNT_W-1.
- DROP_W, 4: width of the saturating dropped-result counter.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- run_i  input  1  upstream `r`; high on each RUN cycle.
- last_i  input  1  upstream `f`; one-cycle pulse after the run ends.
- res_valid  output  1  result queue non-empty.
- res_ready  input  1  consumer accepts the head result.
- res_data  output  CNT_W+1  head result: {sat, len}.
- proto_err  output  1  one-cycle pulse on a protocol violation.
- drop  output  1  one-cycle pulse when a completed result is lost because the queue is full.
- drop_cnt  output  DROP_W  saturating count of dropped results.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State=IDLE, counter=0, queue empty.
  - res_valid=0, res_data=0, proto_err=0, drop=0, drop_cnt=0.
  - Reset mid-burst discards the partial count and any queued results.
- States: IDLE, MEAS.
- IDLE:
  - run_i=1, last_i=0 → MEAS, counter=1.
  - last_i=1 (with or without run_i) → proto_err pulse next cycle; stay IDLE.
  - Otherwise hold.
- MEAS:
  - run_i=1, last_i=0 → counter+1, saturating at 2^CNT_W-1; the sat flag is set once the counter would exceed the maximum.
  - last_i=1, run_i=0 → push {sat, counter} into the queue; counter and sat cleared; → IDLE.
  - run_i=1, last_i=1 → proto_err pulse, burst discarded, → IDLE.
  - run_i=0, last_i=0 (gap) → proto_err pulse, burst discarded, → IDLE.
- Result latency: a result is visible on res_data/res_valid the cycle after the last_i cycle.
  - Example: 3 run cycles then last produce len=3 one clk after last_i.
- Queue (2 entries, FIFO order):
  - res_valid = not empty.
  - Pop when res_valid && res_ready.
  - res_data holds its value while res_valid=1 and res_ready=0.
  - res_data is 0 when the queue is empty.
- Push while full:
  - If a pop happens in the same cycle, push and pop both occur and occupancy stays 2.
  - Otherwise the result is dropped: drop pulses the next cycle and drop_cnt increments, saturating at 2^DROP_W-1.
- Push and pop on an empty queue: no bypass; the result appears the next cycle.
- proto_err and drop are registered, single-cycle, and never held.

Optional Feature:
- Macro: BURST_METER_STATS_EN.
- When defined:
  - Adds output burst_cnt (16 bits), a wrap-around count of results successfully pushed into the queue (drops excluded), reset to 0.
  - Adds output max_len (CNT_W bits), the largest len pushed since reset; saturated results count as 2^CNT_W-1.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package burst_meter_pkg:
  - State enum/localparams IDLE=1'b0, MEAS=1'b1.
  - Result field offsets (SAT_BIT=CNT_W).
  - Default widths.
- Sub-module burst_meter_fifo: 2-entry synchronous FIFO with push/pop/full/empty and pop-while-full-push support, parameterised on data width.
- The FSM, counter and drop logic stay in burst_meter.

Test Plan:
- Basic: run_i=1 for 3 cycles, then last_i pulse, res_ready=1 → res_valid=1 with res_data={0,3} one cycle after last_i; proto_err=0.
- Saturation: CNT_W=4, run_i high 20 cycles, then last → res_data={1,15}.
- Backpressure and drop:
  - res_ready=0, three bursts of length 2, 5, 7.
  - Third burst: drop pulse, drop_cnt=1.
  - Then res_ready=1 → results 2 then 5 in order; res_valid falls afterwards.
- Protocol errors, each → one proto_err pulse, nothing queued, FSM back in IDLE:
  - last_i pulse in IDLE.
  - run_i=1 and last_i=1 together in MEAS.
  - run_i gap with no last_i.
- Reset mid-burst:
  - rst=1 after 4 run cycles with one result queued → res_valid=0, drop_cnt=0 next cycle.
  - A following 2-cycle burst yields len=2.
- Full-queue push with simultaneous pop: queue holds {3,4}, res_ready=1 in the cycle a len=6 result arrives → no drop; outputs 3, 4, 6 in sequence.
  - With BURST_METER_STATS_EN: burst_cnt=3 and max_len=6 at the end.
